// File: rtl/fifo_rd_packer_if.sv
// Read-side bundle: async_fifo read port in, packed wide word out on valid/ready.
// FIFO_RD_PACKER_FLUSH_EN adds i_flush and the per-entry o_keep mask.
interface fifo_rd_packer_if #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned PACK_RATIO = 4
);
   localparam int unsigned WORD_W = DATA_WIDTH * PACK_RATIO;

   logic                  i_empty;
   logic [DATA_WIDTH-1:0] i_rd_data;
   logic                  o_rd_en;
   logic [WORD_W-1:0]     o_data;
   logic                  o_valid;
   logic                  i_ready;
`ifdef FIFO_RD_PACKER_FLUSH_EN
   logic                  i_flush;
   logic [PACK_RATIO-1:0] o_keep;

   modport master (
      input  i_empty, i_rd_data, i_ready, i_flush,
      output o_rd_en, o_data, o_valid, o_keep
   );
   modport slave (
      output i_empty, i_rd_data, i_ready, i_flush,
      input  o_rd_en, o_data, o_valid, o_keep
   );
`else
   modport master (
      input  i_empty, i_rd_data, i_ready,
      output o_rd_en, o_data, o_valid
   );
   modport slave (
      output i_empty, i_rd_data, i_ready,
      input  o_rd_en, o_data, o_valid
   );
`endif
endinterface

// File: rtl/fifo_rd_packer.sv
// Drains async_fifo entries and packs PACK_RATIO of them LSB-first into one registered word.
// FIFO_RD_PACKER_FLUSH_EN enables flushing a partial word out with an o_keep mask.
module fifo_rd_packer #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned PACK_RATIO = 4
) (
   input logic              i_clk,
   input logic              i_rst,
   fifo_rd_packer_if.master bus
);
   localparam int unsigned WORD_W = DATA_WIDTH * PACK_RATIO;
   localparam int unsigned CNT_W  = $clog2(PACK_RATIO + 1);
   localparam int unsigned PEND_W = CNT_W + 1;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              inflight_q, inflight_d;
   logic [WORD_W-1:0] acc_q, acc_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;

   logic [PEND_W-1:0] pending_c;
   logic              out_free_c;
   logic              rd_en_c;
   logic [CNT_W-1:0]  fill_cnt_c;
   logic              full_c;
   logic              xfer_c;
   logic [WORD_W-1:0] word_c;

`ifdef FIFO_RD_PACKER_FLUSH_EN
   logic                  flush_q, flush_d;
   logic [PACK_RATIO-1:0] keep_q, keep_d;
   logic [PACK_RATIO-1:0] keep_c;
   logic                  flush_go_c;
`endif

   // Pop request: keep at most PACK_RATIO entries owned, overlap the last capture with a free output.
   always_comb begin
      pending_c  = PEND_W'(cnt_q) + PEND_W'(inflight_q);
      out_free_c = !valid_q || bus.i_ready;
      rd_en_c    = 1'b0;
      if (!i_rst && !bus.i_empty) begin
         if (pending_c < PEND_W'(PACK_RATIO)) begin
            rd_en_c = 1'b1;
         end else if (pending_c == PEND_W'(PACK_RATIO) && inflight_q && out_free_c) begin
            rd_en_c = 1'b1;
         end
      end
`ifdef FIFO_RD_PACKER_FLUSH_EN
      if (flush_q) begin
         rd_en_c = 1'b0;
      end
`endif
   end

   // Capture the in-flight entry into its slot.
   always_comb begin
      acc_d = acc_q;
      for (int unsigned k = 0; k < PACK_RATIO; k++) begin
         if (inflight_q && cnt_q == CNT_W'(k)) begin
            acc_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.i_rd_data;
         end
      end
      fill_cnt_c = inflight_q ? cnt_q + CNT_W'(1) : cnt_q;
      full_c     = (fill_cnt_c == CNT_W'(PACK_RATIO));
   end

   // Move a completed (or flushed partial) word into the output register.
   always_comb begin
      word_c     = acc_d;
      xfer_c     = full_c && out_free_c;
      inflight_d = rd_en_c;
`ifdef FIFO_RD_PACKER_FLUSH_EN
      flush_go_c = flush_q && !inflight_q;
      for (int unsigned k = 0; k < PACK_RATIO; k++) begin
         keep_c[k] = (CNT_W'(k) < fill_cnt_c);
         if (!keep_c[k]) begin
            word_c[k*DATA_WIDTH +: DATA_WIDTH] = '0;
         end
      end
      xfer_c  = out_free_c && (full_c || (flush_go_c && cnt_q != '0));
      flush_d = flush_q ? !(flush_go_c && (cnt_q == '0 || out_free_c)) : bus.i_flush;
      keep_d  = keep_q;
`endif
      valid_d = valid_q;
      data_d  = data_q;
      cnt_d   = fill_cnt_c;
      if (xfer_c) begin
         data_d  = word_c;
         valid_d = 1'b1;
         cnt_d   = '0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
         keep_d  = keep_c;
`endif
      end else if (valid_q && bus.i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q      <= '0;
         inflight_q <= 1'b0;
         acc_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
         flush_q    <= 1'b0;
         keep_q     <= '0;
`endif
      end else begin
         cnt_q      <= cnt_d;
         inflight_q <= inflight_d;
         acc_q      <= acc_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
`ifdef FIFO_RD_PACKER_FLUSH_EN
         flush_q    <= flush_d;
         keep_q     <= keep_d;
`endif
      end
   end

   assign bus.o_rd_en = rd_en_c;
   assign bus.o_data  = data_q;
   assign bus.o_valid = valid_q;
`ifdef FIFO_RD_PACKER_FLUSH_EN
   assign bus.o_keep  = keep_q;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model on the read side, word scoreboard on the output.
// Flush scenarios are exercised when FIFO_RD_PACKER_FLUSH_EN is defined.
module tb_fifo_rd_packer;
   localparam int unsigned DW = 4;
   localparam int unsigned PR = 4;
   localparam int unsigned WW = DW * PR;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) bus ();

   fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   logic [DW-1:0] fifo_q[$];
   logic [WW-1:0] exp_q[$];
   logic [PR-1:0] expk_q[$];
   logic [WW-1:0] part_word;
   int            part_n;
   int            words_made;

   int n_pass, n_fail, n_chk;
   int cyc;
   int pops, first_pop, last_pop, first_valid, valid_cyc;
   int n_acc, first_acc, last_acc;
   logic [WW-1:0] first_word, last_word, data_prev;
   logic [PR-1:0] first_keep;
   logic          hold_prev;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: every PR pushed entries form one word, first entry in the low slot.
   task automatic push(input logic [DW-1:0] v);
      fifo_q.push_back(v);
      bus.i_empty = 1'b0;
      part_word = part_word | (WW'(v) << (DW * part_n));
      part_n++;
      if (part_n == int'(PR)) begin
         exp_q.push_back(part_word);
         expk_q.push_back('1);
         words_made++;
         part_word = '0;
         part_n    = 0;
      end
   endtask

   task automatic model_flush();
      if (part_n > 0) begin
         exp_q.push_back(part_word);
         expk_q.push_back(PR'((1 << part_n) - 1));
      end
      part_word = '0;
      part_n    = 0;
   endtask

   task automatic model_reset();
      fifo_q.delete();
      exp_q.delete();
      expk_q.delete();
      part_word   = '0;
      part_n      = 0;
      hold_prev   = 1'b0;
      bus.i_empty = 1'b1;
   endtask

   task automatic clear_stats();
      pops = 0; first_pop = -1; last_pop = -1; first_valid = -1; valid_cyc = 0;
      n_acc = 0; first_acc = -1; last_acc = -1;
      first_word = 'x; last_word = 'x; first_keep = 'x;
   endtask

   // One clock: observe mid-cycle, then advance FIFO model at the edge.
   task automatic tick();
      logic pop;
      logic [WW-1:0] w;
      @(negedge clk);
      pop = bus.o_rd_en;
      if (pop) begin
         chk("no_pop_when_empty", 32'(bus.i_empty), 32'(0));
         pops++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
      end
      if (hold_prev) begin
         chk("hold_valid", 32'(bus.o_valid), 32'(1));
         chk("hold_data", 32'(bus.o_data), 32'(data_prev));
      end
      if (bus.o_valid === 1'b1) begin
         valid_cyc++;
         if (first_valid < 0) first_valid = cyc;
      end
      if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_word", 32'(bus.o_valid), 32'(0));
         end else begin
            w = exp_q.pop_front();
            chk("word", 32'(bus.o_data), 32'(w));
`ifdef FIFO_RD_PACKER_FLUSH_EN
            chk("keep", 32'(bus.o_keep), 32'(expk_q.pop_front()));
            if (n_acc == 0) first_keep = bus.o_keep;
`else
            void'(expk_q.pop_front());
`endif
            if (n_acc == 0) begin
               first_word = bus.o_data;
               first_acc  = cyc;
            end
            last_word = bus.o_data;
            last_acc  = cyc;
            n_acc++;
         end
      end
      hold_prev = (bus.o_valid === 1'b1) && (bus.i_ready === 1'b0);
      data_prev = bus.o_data;
      @(posedge clk);
      if (pop && fifo_q.size() > 0) begin
         bus.i_rd_data <= fifo_q.pop_front();
      end
      bus.i_empty <= (fifo_q.size() == 0);
      cyc++;
      #1;
   endtask

   initial begin
      n_pass = 0; n_fail = 0; n_chk = 0; cyc = 0; words_made = 0;
      rst = 1'b1;
      bus.i_ready   = 1'b1;
      bus.i_rd_data = '0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
      bus.i_flush   = 1'b0;
`endif
      model_reset();
      clear_stats();
      repeat (2) tick();

      // Reset with a preloaded FIFO: no pops, outputs cleared.
      for (int i = 2; i <= 9; i++) push(DW'(i));
      tick();
      chk("rst_rd_en", 32'(bus.o_rd_en), 32'(0));
      chk("rst_valid", 32'(bus.o_valid), 32'(0));
      chk("rst_data", 32'(bus.o_data), 32'(0));

      // Back-to-back drain with a free output.
      clear_stats();
      rst = 1'b0;
      repeat (14) tick();
      chk("t1_pops", 32'(pops), 32'(8));
      chk("t1_pop_span", 32'(last_pop - first_pop), 32'(7));
      chk("t1_valid_latency", 32'(first_valid - first_pop), 32'(PR + 1));
      chk("t1_valid_cycles", 32'(valid_cyc), 32'(2));
      chk("t1_first_word", 32'(first_word), 32'h5432);
      chk("t1_second_word", 32'(last_word), 32'h9876);

      // Back-pressure: first word held, second waits in the accumulator.
      clear_stats();
      bus.i_ready = 1'b0;
      for (int i = 2; i <= 9; i++) push(DW'(i));
      repeat (14) tick();
      chk("t2_pops", 32'(pops), 32'(8));
      chk("t2_held_valid", 32'(bus.o_valid), 32'(1));
      chk("t2_held_data", 32'(bus.o_data), 32'h5432);
      chk("t2_no_accept", 32'(n_acc), 32'(0));
      bus.i_ready = 1'b1;
      repeat (4) tick();
      chk("t2_words", 32'(n_acc), 32'(2));
      chk("t2_consecutive", 32'(last_acc - first_acc), 32'(1));
      chk("t2_first_word", 32'(first_word), 32'h5432);
      chk("t2_second_word", 32'(last_word), 32'h9876);
      chk("t2_valid_drop", 32'(bus.o_valid), 32'(0));

      // Empty gap of three cycles mid-word.
      clear_stats();
      push(DW'(2)); push(DW'(3));
      repeat (5) tick();
      push(DW'(4)); push(DW'(5));
      repeat (10) tick();
      chk("t3_pops", 32'(pops), 32'(4));
      chk("t3_pop_span", 32'(last_pop - first_pop), 32'(6));
      chk("t3_valid_latency", 32'(first_valid - first_pop), 32'(8));
      chk("t3_word", 32'(first_word), 32'h5432);

      // Reset after two captures, then a clean word.
      clear_stats();
      push(DW'(1)); push(DW'(2)); push(DW'(3)); push(DW'(4));
      repeat (3) tick();
      rst = 1'b1;
      model_reset();
      #1;
      chk("t4_rst_rd_en", 32'(bus.o_rd_en), 32'(0));
      tick();
      chk("t4_rst_valid", 32'(bus.o_valid), 32'(0));
      chk("t4_rst_data", 32'(bus.o_data), 32'(0));
      rst = 1'b0;
      push(DW'(4'hA)); push(DW'(4'hB)); push(DW'(4'hC)); push(DW'(4'hD));
      repeat (10) tick();
      chk("t4_words", 32'(n_acc), 32'(1));
      chk("t4_word", 32'(first_word), 32'hDCBA);

      // Random traffic and back-pressure against the reference queue.
      clear_stats();
      words_made = 0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(2) != 0) push(DW'($urandom_range(15)));
         bus.i_ready = ($urandom_range(3) != 0);
         tick();
      end
      while (part_n != 0) push(DW'($urandom_range(15)));
      bus.i_ready = 1'b1;
      for (int i = 0; i < 600 && (exp_q.size() != 0 || fifo_q.size() != 0); i++) tick();
      repeat (4) tick();
      chk("rand_words_left", 32'(exp_q.size()), 32'(0));
      chk("rand_words", 32'(n_acc), 32'(words_made));
      chk("rand_idle_valid", 32'(bus.o_valid), 32'(0));

`ifdef FIFO_RD_PACKER_FLUSH_EN
      // Flush a two-entry partial word.
      clear_stats();
      push(DW'(3)); push(DW'(7));
      repeat (4) tick();
      bus.i_flush = 1'b1;
      tick();
      bus.i_flush = 1'b0;
      model_flush();
      repeat (5) tick();
      chk("f1_words", 32'(n_acc), 32'(1));
      chk("f1_data", 32'(first_word), 32'h0073);
      chk("f1_keep", 32'(first_keep), 32'b0011);

      // Flush with nothing accumulated, then normal packing resumes.
      clear_stats();
      bus.i_flush = 1'b1;
      tick();
      bus.i_flush = 1'b0;
      repeat (5) tick();
      chk("f2_no_valid", 32'(valid_cyc), 32'(0));
      push(DW'(1)); push(DW'(2)); push(DW'(3)); push(DW'(4));
      repeat (10) tick();
      chk("f2_resume_word", 32'(first_word), 32'h4321);
      chk("f2_resume_keep", 32'(first_keep), 32'hF);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side drain stage placed directly downstream of `async_fifo`, in the FIFO's read-clock domain. It pops narrow entries whenever the FIFO is non-empty and packs `PACK_RATIO` consecutive entries LSB-first into one wide word. It presents each word on a valid/ready output with a registered output stage. The accumulator and output register are independent, so the block sustains one pop per cycle under back-pressure-free conditions.

## Interface

- `DATA_WIDTH`, 4, FIFO entry width; must match the FIFO's `DATA_WIDTH`.
- `PACK_RATIO`, 4, entries per output word (≥2).
- `i_clk`  input  1  read-domain clock; the same clock as the FIFO `i_rd_clk`.
- `i_rst`  input  1  reset, synchronous, active-high.
- `i_empty`  input  1  FIFO `o_empty`.
- `i_rd_data`  input  DATA_WIDTH  FIFO `o_rd_data`; valid the cycle after a pop.
- `o_rd_en`  output  1  pop request to FIFO `i_rd_en`.
- `o_data`  output  DATA_WIDTH*PACK_RATIO  packed word; entry k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `o_valid`  output  1  `o_data` holds a word.
- `i_ready`  input  1  downstream accepts the word.
- `i_flush`  input  1  present only with `FIFO_RD_PACKER_FLUSH_EN`.
- `o_keep`  output  PACK_RATIO  per-entry valid mask; present only with `FIFO_RD_PACKER_FLUSH_EN`.

## Operation

- **Registers**
  - `cnt`: entries captured in the accumulator, 0..PACK_RATIO, width clog2(PACK_RATIO+1).
  - `inflight`: 1 if a pop was issued in the previous cycle.
  - `acc`: the accumulator.
  - `o_data`, `o_valid` and, with the macro, `o_keep`.
- **Reset values:** `o_valid`=0, `o_data`=0, `o_keep`=0, `cnt`=0, `inflight`=0. `o_rd_en` is 0 whenever `i_rst`=1. Reset mid-operation discards the partial accumulator, the in-flight entry and any held output word. Resetting the FIFO is a separate responsibility.
- **Pop rule:** `o_rd_en` is combinational. With pending = `cnt`+`inflight`:
  - `o_rd_en` = !`i_rst` & !`i_empty` & (pending < PACK_RATIO | (pending == PACK_RATIO & `inflight` & out_free)).
  - out_free = !`o_valid` | `i_ready`.
- **Capture:** when `inflight`=1, `i_rd_data` is written into `acc` slot `cnt` on that edge.
- **Completion:** if that capture fills slot PACK_RATIO-1 and out_free, the full word moves into `o_data` on the same edge, `o_valid`=1 and `cnt` returns to 0.
  - If not out_free, `cnt`=PACK_RATIO and the accumulator holds.
  - A held accumulator transfers on the first edge where out_free=1, and popping resumes in the following cycle.
- **Handshake:** a word is accepted on an edge where `o_valid`&`i_ready`. `o_data` is stable while `o_valid`=1 and `i_ready`=0. On acceptance with no new word, `o_valid` drops on that edge.
- **Simultaneous events:** acceptance and a new transfer on the same edge leave `o_valid`=1 with the new word.
- **Empty:** the block never pops while `i_empty`=1. `i_empty` toggling mid-word simply stalls the fill, and partial words persist indefinitely.

## Timing

- Pop-to-capture latency is 1 cycle.
- From the first of PACK_RATIO back-to-back pops at cycle t, `o_valid` rises at t+PACK_RATIO+1.
- Sustained throughput with `i_ready`=1 and a non-empty FIFO: one pop per cycle, one word per PACK_RATIO cycles.
- `o_valid`, `o_data` and `o_keep` are registered. `o_rd_en` has a combinational path from `i_empty`, `i_ready` and `i_rst` only.

## Configuration

- **`FIFO_RD_PACKER_FLUSH_EN` defined:** adds `i_flush` and `o_keep`.
  - A 1-cycle `i_flush` pulse is latched as a pending flush. `o_rd_en` is forced to 0 until the flush completes.
  - After `inflight` clears: if `cnt`>0, the partial word transfers when out_free. Unused upper slots are 0, and `o_keep` has its low `cnt` bits set.
  - If `cnt`=0 the flush clears with no output.
  - Full words carry `o_keep` all ones.
  - `i_flush` while a flush is already pending is ignored.
- **Not defined:** neither port exists, and only full words are emitted.

## Test plan

- Reset, then 8 entries 2..9 preloaded, `i_ready`=1 → `o_rd_en` high for 8 consecutive cycles; words 0x5432 then 0x9876 with `o_valid` 1 cycle each, the first at pop0+5.
- Same load with `i_ready`=0 → 0x5432 held stable. The accumulator fills to 0x9876 and pops stop after 8. Raising `i_ready` delivers 0x5432 and then 0x9876 on consecutive cycles.
- `i_empty` high for 3 cycles after the 2nd entry → no pops during the gap, and the word 0x5432 is still correct, delayed 3 cycles.
- `i_rst` asserted after 2 captures → all outputs 0 the next cycle. New entries A,B,C,D then yield 0xDCBA with no stale nibbles.
- With the macro: 2 entries 3,7 then `i_flush` → `o_data`=0x0073, `o_keep`=4'b0011. A flush with `cnt`=0 produces no `o_valid`.
